// File: rtl/ppu_pkg.sv
// Shared PPU constants: dot/line windows, sprite attribute bit positions and
// the pattern-table address layout used by the sprite fetcher.
package ppu_pkg;

  localparam int unsigned NUM_SLOTS = 8;

  localparam logic [9:0] RENDER_FIRST   = 10'd1;
  localparam logic [9:0] RENDER_LAST    = 10'd256;
  localparam logic [9:0] FETCH_FIRST    = 10'd257;
  localparam logic [9:0] FETCH_LAST     = 10'd320;
  localparam logic [9:0] SPR0_LATCH_DOT = 10'd256;

  localparam logic [9:0] LINE_VIS_FIRST = 10'd1;
  localparam logic [9:0] LINE_VIS_LAST  = 10'd240;

  localparam int unsigned ATTR_VFLIP   = 7;
  localparam int unsigned ATTR_HFLIP   = 6;
  localparam int unsigned ATTR_PRIO    = 5;
  localparam int unsigned ATTR_PAL_MSB = 1;
  localparam int unsigned ATTR_PAL_LSB = 0;

  // Eight cycles per slot; the phase is the low three bits of (x_idx - 257).
  typedef enum logic [2:0] {
    PH_Y_ADDR   = 3'd0,
    PH_Y_CAP    = 3'd1,
    PH_TILE_CAP = 3'd2,
    PH_ATTR_CAP = 3'd3,
    PH_X_CAP    = 3'd4,
    PH_LO_CAP   = 3'd5,
    PH_HI_ADDR  = 3'd6,
    PH_HI_CAP   = 3'd7
  } fetch_phase_t;

  typedef struct packed {
    logic [2:0] zero;
    logic       pt_sel;
    logic [7:0] tile;
    logic       plane;
    logic [2:0] row;
  } pat_addr_t;

  function automatic logic [15:0] pattern_addr(input logic       pt_sel,
                                               input logic [7:0] tile,
                                               input logic       plane,
                                               input logic [2:0] row);
    pat_addr_t a;
    a.zero   = 3'b000;
    a.pt_sel = pt_sel;
    a.tile   = tile;
    a.plane  = plane;
    a.row    = row;
    return a;
  endfunction

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ppu_spr_unit.sv
// One sprite output slot: X down-counter, palette/priority attributes and the
// two pattern shifters that emit one pixel per render dot once X reaches zero.
module ppu_spr_unit
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_x,
  input  logic [1:0] load_pal,
  input  logic       load_prio,
  input  logic [7:0] load_lo,
  input  logic [7:0] load_hi,
  input  logic       shift_en,
  output logic [1:0] pix,
  output logic [1:0] pal,
  output logic       prio
);

  logic [7:0] x_cnt_reg;
  logic [7:0] lo_reg;
  logic [7:0] hi_reg;
  logic [1:0] pal_reg;
  logic       prio_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_cnt_reg <= 8'd0;
      lo_reg    <= 8'd0;
      hi_reg    <= 8'd0;
      pal_reg   <= 2'd0;
      prio_reg  <= 1'b0;
    end else if (load) begin
      x_cnt_reg <= load_x;
      lo_reg    <= load_lo;
      hi_reg    <= load_hi;
      pal_reg   <= load_pal;
      prio_reg  <= load_prio;
    end else if (shift_en) begin
      if (x_cnt_reg != 8'd0) begin
        x_cnt_reg <= x_cnt_reg - 8'd1;
      end else begin
        // Zero fill makes the slot transparent once its eight pixels are out.
        lo_reg <= {lo_reg[6:0], 1'b0};
        hi_reg <= {hi_reg[6:0], 1'b0};
      end
    end
  end

  assign pix  = (x_cnt_reg == 8'd0) ? {hi_reg[7], lo_reg[7]} : 2'b00;
  assign pal  = pal_reg;
  assign prio = prio_reg;

endmodule

// File: rtl/ppu_spr_fetch.sv
// Sprite pattern fetch (dots 257..320) from secondary OAM and VRAM into eight
// output slots, and the per-dot priority mux producing the registered sprite pixel.
module ppu_spr_fetch
  import ppu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x_idx,
  input  logic [9:0]  scanline,
  input  logic        spr_pt_addr,
  input  logic [3:0]  spr_count,
  input  logic        spr0_found,
  output logic [4:0]  s_oam_addr,
  input  logic [7:0]  s_oam_data,
  output logic [15:0] VRAM_addr,
  input  logic [7:0]  VRAM_data_in,
  output logic [3:0]  pixel,
  output logic        spr_priority,
  output logic        spr0_opaque
);

  logic         in_fetch;
  logic         in_render;
  logic         vis_line;
  logic [5:0]   fetch_off;
  logic [2:0]   slot;
  fetch_phase_t phase;

  assign in_fetch  = (x_idx >= FETCH_FIRST) && (x_idx <= FETCH_LAST);
  assign in_render = (x_idx >= RENDER_FIRST) && (x_idx <= RENDER_LAST);
  assign vis_line  = (scanline >= LINE_VIS_FIRST) && (scanline <= LINE_VIS_LAST);
  assign fetch_off = 6'(x_idx - FETCH_FIRST);
  assign slot      = fetch_off[5:3];
  assign phase     = fetch_phase_t'(fetch_off[2:0]);

  logic [7:0]  y_reg;
  logic [7:0]  tile_reg;
  logic [7:0]  x_reg;
  logic [7:0]  lo_reg;
  logic        vflip_reg;
  logic        hflip_reg;
  logic        prio_reg;
  logic [1:0]  pal_reg;
  logic        armed_reg;
  logic        spr0_latch_reg;
  logic [4:0]  s_oam_addr_reg;
  logic [15:0] vram_addr_reg;
  logic [3:0]  pixel_reg;
  logic        priority_reg;
  logic        spr0_opaque_reg;

  logic [2:0] row_raw;
  logic [2:0] row;

  // Row within the tile for the line being fetched for; truncation is intended.
  assign row_raw = 3'(scanline - 10'd1 - {2'b00, y_reg});
  assign row     = vflip_reg ? ~row_raw : row_raw;

  logic       slot_live;
  logic       load_cycle;
  logic [7:0] lo_load;
  logic [7:0] hi_load;

  assign slot_live  = ({1'b0, slot} < spr_count);
  // armed_reg blocks loads from a window that began before reset was released.
  assign load_cycle = in_fetch && (phase == PH_HI_CAP) && armed_reg;
  assign lo_load    = !slot_live ? 8'h00 : (hflip_reg ? bit_rev8(lo_reg) : lo_reg);
  assign hi_load    = !slot_live ? 8'h00 :
                      (hflip_reg ? bit_rev8(VRAM_data_in) : VRAM_data_in);

  logic [1:0] unit_pix  [NUM_SLOTS];
  logic [1:0] unit_pal  [NUM_SLOTS];
  logic       unit_prio [NUM_SLOTS];

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_unit
      ppu_spr_unit u_unit (
        .clk      (clk),
        .reset    (reset),
        .load     (load_cycle && (slot == 3'(gi))),
        .load_x   (x_reg),
        .load_pal (pal_reg),
        .load_prio(prio_reg),
        .load_lo  (lo_load),
        .load_hi  (hi_load),
        .shift_en (in_render),
        .pix      (unit_pix[gi]),
        .pal      (unit_pal[gi]),
        .prio     (unit_prio[gi])
      );
    end
  endgenerate

  logic [3:0] win_pix;
  logic       win_prio;
  logic       win_slot0;

  // Walk from the highest slot down so the lowest opaque slot is left standing.
  always_comb begin
    win_pix   = 4'd0;
    win_prio  = 1'b0;
    win_slot0 = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (unit_pix[i] != 2'b00) begin
        win_pix   = {unit_pal[i], unit_pix[i]};
        win_prio  = unit_prio[i];
        win_slot0 = (i == 0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_reg           <= 8'd0;
      tile_reg        <= 8'd0;
      x_reg           <= 8'd0;
      lo_reg          <= 8'd0;
      vflip_reg       <= 1'b0;
      hflip_reg       <= 1'b0;
      prio_reg        <= 1'b0;
      pal_reg         <= 2'd0;
      armed_reg       <= 1'b0;
      spr0_latch_reg  <= 1'b0;
      s_oam_addr_reg  <= 5'd0;
      vram_addr_reg   <= 16'd0;
      pixel_reg       <= 4'd0;
      priority_reg    <= 1'b0;
      spr0_opaque_reg <= 1'b0;
    end else begin
      if (x_idx == SPR0_LATCH_DOT) begin
        spr0_latch_reg <= spr0_found;
      end
      if (x_idx == FETCH_FIRST) begin
        armed_reg <= 1'b1;
      end

      if (in_fetch) begin
        case (phase)
          PH_Y_ADDR: begin
            s_oam_addr_reg <= {slot, 2'd0};
          end
          PH_Y_CAP: begin
            y_reg          <= s_oam_data;
            s_oam_addr_reg <= {slot, 2'd1};
          end
          PH_TILE_CAP: begin
            tile_reg       <= s_oam_data;
            s_oam_addr_reg <= {slot, 2'd2};
          end
          PH_ATTR_CAP: begin
            vflip_reg      <= s_oam_data[ATTR_VFLIP];
            hflip_reg      <= s_oam_data[ATTR_HFLIP];
            prio_reg       <= s_oam_data[ATTR_PRIO];
            pal_reg        <= s_oam_data[ATTR_PAL_MSB:ATTR_PAL_LSB];
            s_oam_addr_reg <= {slot, 2'd3};
          end
          PH_X_CAP: begin
            x_reg         <= s_oam_data;
            vram_addr_reg <= pattern_addr(spr_pt_addr, tile_reg, 1'b0, row);
          end
          PH_LO_CAP: begin
            lo_reg <= VRAM_data_in;
          end
          PH_HI_ADDR: begin
            vram_addr_reg <= pattern_addr(spr_pt_addr, tile_reg, 1'b1, row);
          end
          default: begin
          end
        endcase
      end

      if (in_render && vis_line) begin
        pixel_reg       <= win_pix;
        priority_reg    <= win_prio;
        spr0_opaque_reg <= win_slot0 && spr0_latch_reg;
      end else begin
        pixel_reg       <= 4'd0;
        priority_reg    <= 1'b0;
        spr0_opaque_reg <= 1'b0;
      end
    end
  end

  assign s_oam_addr   = s_oam_addr_reg;
  assign VRAM_addr    = vram_addr_reg;
  assign pixel        = pixel_reg;
  assign spr_priority = priority_reg;
  assign spr0_opaque  = spr0_opaque_reg;

endmodule
